// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bundle between a requester and the muldiv unit.
//
// Request channel : in_valid, in_ready, op, srca, srcb
// Response channel: out_valid, out_ready, out
//
// Modports:
//   master - the requester: drives the request and out_ready, observes the rest
//   slave  - the muldiv unit: the mirror image of master
interface muldiv_if #(
  parameter int XLEN      = 32,
  parameter int MD_OP_LEN = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MD_OP_LEN-1:0] op;
  logic [XLEN-1:0]      srca;
  logic [XLEN-1:0]      srcb;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out;

  modport master (
    output in_valid, op, srca, srcb, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, op, srca, srcb, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/muldiv.sv
// muldiv -- iterative RISC-V M-extension multiply/divide unit.
//
// One radix-2 step per cycle: shift-add for the multiplies, restoring
// shift-subtract for the divides, both on operand magnitudes with the sign
// applied once at the end. Divide-by-zero, signed overflow and unknown op
// codes skip the iterations and complete one cycle after acceptance.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset, highest priority
//   flush - synchronous abort back to IDLE, result discarded
//   bus   - muldiv_if.slave: in_valid/in_ready/op/srca/srcb request,
//           out_valid/out_ready/out registered response
module muldiv #(
  parameter int XLEN      = 32,
  parameter int MD_OP_LEN = 3
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        fn;
  logic              neg;
  logic              fast;
  logic [XLEN-1:0]   mreg;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   out_q;

  logic accept;
  assign accept = bus.in_valid && (state == IDLE) && !flush;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [2:0] in_fn;
  logic       op_unknown;
  assign in_fn = bus.op[2:0];

  // Only a wider op field can carry codes beyond the eight M-extension ops.
  if (MD_OP_LEN > 3) begin : g_wide_op
    assign op_unknown = |bus.op[MD_OP_LEN-1:3];
  end else begin : g_narrow_op
    assign op_unknown = 1'b0;
  end

  logic            in_is_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            in_fast;
  logic            in_neg;
  logic [XLEN-1:0] fast_res;

  // MUL is treated as unsigned: the low half of the product does not depend
  // on operand signedness.
  assign in_is_div = in_fn[2];
  assign a_signed  = (in_fn == 3'd1) || (in_fn == 3'd2) || (in_fn == 3'd4) || (in_fn == 3'd6);
  assign b_signed  = (in_fn == 3'd1) || (in_fn == 3'd4) || (in_fn == 3'd6);
  assign a_neg     = a_signed && bus.srca[XLEN-1];
  assign b_neg     = b_signed && bus.srcb[XLEN-1];
  assign a_mag     = a_neg ? (XLEN'(0) - bus.srca) : bus.srca;
  assign b_mag     = b_neg ? (XLEN'(0) - bus.srcb) : bus.srcb;
  assign div_zero  = in_is_div && (bus.srcb == '0);
  assign div_ovf   = in_is_div && !in_fn[0] && (bus.srca == INT_MIN) && (bus.srcb == '1);
  assign in_fast   = op_unknown || div_zero || div_ovf;
  // The remainder follows the dividend's sign; everything else is the XOR.
  assign in_neg    = (in_is_div && in_fn[1]) ? a_neg : (a_neg ^ b_neg);

  // Result of the ops that bypass the iterations; fn[1] selects REM/REMU.
  always_comb begin
    fast_res = '0;
    if (!op_unknown) begin
      if (div_zero) begin
        fast_res = in_fn[1] ? bus.srca : '1;
      end else if (div_ovf) begin
        fast_res = in_fn[1] ? '0 : bus.srca;
      end
    end
  end

  // ---------------------------------------------------------------------
  // One iteration. acc is {hi, lo}: for multiply hi is the running partial
  // product and lo the remaining multiplier bits; for divide hi is the
  // partial remainder and lo the dividend shifting out / quotient shifting in.
  // ---------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] acc_step;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mreg} : '0);
  assign mul_step  = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, mreg};
  // When the divisor fits, the difference is below the divisor, so XLEN bits suffice.
  assign div_diff  = div_shift[XLEN-1:0] - mreg;
  assign div_step  = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  assign acc_step  = fn[2] ? div_step : mul_step;

  // Sign-corrected result taken from the value the last iteration produces.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res;

  assign prod_fix = neg ? ((2*XLEN)'(0) - acc_step) : acc_step;
  assign quo      = acc_step[XLEN-1:0];
  assign rem      = acc_step[2*XLEN-1:XLEN];

  always_comb begin
    res = '0;
    case (fn)
      3'd0:                res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res = neg ? (XLEN'(0) - quo) : quo;
      default:             res = neg ? (XLEN'(0) - rem) : rem;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // State register; reset beats flush and accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: fast-path ops spend exactly one cycle in BUSY; flush wins
  // over every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (fast || (cnt == LAST)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: capture on accept, iterate in BUSY, register the result on the
  // final step. A fast-path result is parked in the low half of acc so no
  // extra register is needed. out is left alone in DONE and on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      fn    <= '0;
      neg   <= 1'b0;
      fast  <= 1'b0;
      mreg  <= '0;
      acc   <= '0;
      out_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt  <= '0;
            fn   <= in_fn;
            neg  <= in_neg;
            fast <= in_fast;
            mreg <= in_is_div ? b_mag : a_mag;
            acc  <= in_fast ? {{XLEN{1'b0}}, fast_res}
                            : {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
          end
        end
        BUSY: begin
          if (fast) begin
            out_q <= acc[XLEN-1:0];
          end else begin
            acc <= acc_step;
            if (cnt == LAST) begin
              cnt   <= '0;
              out_q <= res;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv -- self-checking bench for muldiv.
//
// Drives a 32-bit and an 8-bit instance from one shared set of stimulus
// variables (use8 steers in_valid to one of them). A directed vector table
// covers the documented corner results and latencies; hand-written sequences
// cover backpressure, flush and reset; random ops on both widths are compared
// against a plain-arithmetic reference model.
module tb_muldiv;

  logic clk;
  logic reset;
  logic flush;

  logic        use8;
  logic        v_drv;
  logic [2:0]  op_drv;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic        rdy_drv;

  muldiv_if #(.XLEN(32), .MD_OP_LEN(3)) b32 ();
  muldiv_if #(.XLEN(8),  .MD_OP_LEN(3)) b8 ();

  muldiv #(.XLEN(32), .MD_OP_LEN(3)) dut32 (.clk(clk), .reset(reset), .flush(flush), .bus(b32));
  muldiv #(.XLEN(8),  .MD_OP_LEN(3)) dut8  (.clk(clk), .reset(reset), .flush(flush), .bus(b8));

  assign b32.in_valid  = v_drv && !use8;
  assign b32.op        = op_drv;
  assign b32.srca      = a_drv;
  assign b32.srcb      = b_drv;
  assign b32.out_ready = rdy_drv;
  assign b8.in_valid   = v_drv && use8;
  assign b8.op         = op_drv;
  assign b8.srca       = a_drv[7:0];
  assign b8.srcb       = b_drv[7:0];
  assign b8.out_ready  = rdy_drv;

  logic        cur_in_ready;
  logic        cur_out_valid;
  logic [31:0] cur_out;
  assign cur_in_ready  = use8 ? b8.in_ready  : b32.in_ready;
  assign cur_out_valid = use8 ? b8.out_valid : b32.out_valid;
  assign cur_out       = use8 ? {24'b0, b8.out} : b32.out;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands
  // ---------------------------------------------------------------------
  function automatic longint sext(input logic [31:0] v, input int w);
    longint t;
    t = longint'({32'b0, v}) << (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic longint zext(input logic [31:0] v, input int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    return longint'({32'b0, v}) & mask;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    longint      sa, sb, ua, ub, r, mask;
    logic [63:0] pu;
    sa   = sext(a, w);
    sb   = sext(b, w);
    ua   = zext(a, w);
    ub   = zext(b, w);
    mask = (longint'(1) << w) - 1;
    r    = 0;
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: begin
        pu = $unsigned(ua) * $unsigned(ub);
        r  = longint'(pu >> w);
      end
      3'd4: r = (ub == 0) ? -1 : sa / sb;
      3'd5: r = (ub == 0) ? -1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int expLat(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int w);
    if (op[2] && zext(b, w) == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && sext(a, w) == -(longint'(1) << (w - 1)) && sext(b, w) == -1)
      return 1;
    return w;
  endfunction

  // ---------------------------------------------------------------------
  // Tasks
  // ---------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for out_valid after an accept edge; lat counts edges
  // after the accept edge, 0 on timeout.
  task automatic waitResult(output logic [31:0] res, output int lat);
    lat = 0;
    res = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (cur_out_valid) begin
        lat = k;
        res = cur_out;
        break;
      end
    end
    if (lat == 0) checkOutput("result timeout out_valid", 32'(cur_out_valid), 32'd1);
  endtask

  // Issues one request from IDLE, scrambles the inputs after the accept edge
  // and collects the result; with out_ready high it also lets the unit return
  // to IDLE.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat);
    @(negedge clk);
    checkOutput("in_ready before request", 32'(cur_in_ready), 32'd1);
    v_drv  = 1'b1;
    op_drv = op;
    a_drv  = a;
    b_drv  = b;
    @(posedge clk); #1;
    v_drv  = 1'b0;
    op_drv = 3'($urandom);
    a_drv  = $urandom;
    b_drv  = $urandom;
    waitResult(res, lat);
    if (rdy_drv && lat != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic genOperands(input int w, output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
    logic [31:0] mask;
    int          sel;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    op   = 3'($urandom_range(0, 7));
    sel  = $urandom_range(0, 7);
    a    = $urandom & mask;
    b    = $urandom & mask;
    if (sel == 0) b = '0;
    if (sel == 1) begin
      a = 32'(1) << (w - 1);
      b = mask;
    end
    if (sel == 2) b = $urandom_range(1, 5);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [31:0] res;
    logic [31:0] a, b;
    logic [2:0]  op;
    int          lat;
    int          seen;

    vecs[0]  = '{"MUL max*max",       3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32};
    vecs[1]  = '{"MULHU max*max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
    vecs[2]  = '{"MULH -1*-1",        3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32};
    vecs[3]  = '{"MULHSU -1*2",       3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32};
    vecs[4]  = '{"DIV -7/2",          3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
    vecs[5]  = '{"REM -7/2",          3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
    vecs[6]  = '{"DIVU 7/2",          3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 32};
    vecs[7]  = '{"REMU 7/2",          3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32};
    vecs[8]  = '{"DIV 5/0",           3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{"REM 5/0",           3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[10] = '{"DIV min/-1",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"REM min/-1",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{"REMU 9/0",          3'd7, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1};

    reset   = 1'b1;
    flush   = 1'b0;
    use8    = 1'b0;
    v_drv   = 1'b1;
    op_drv  = 3'd0;
    a_drv   = 32'd3;
    b_drv   = 32'd4;
    rdy_drv = 1'b1;

    // Reset state, with a request pending that must not be taken
    @(posedge clk); #1;
    checkOutput("reset in_ready", 32'(b32.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(b32.out_valid), 32'd0);
    checkOutput("reset out", b32.out, 32'd0);
    checkOutput("reset out_valid 8", 32'(b8.out_valid), 32'd0);
    v_drv = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      checkOutput({vecs[i].name, " result"}, res, vecs[i].exp_out);
      checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: result held 10 cycles, a new request waits for IDLE
    rdy_drv = 1'b0;
    applyStimulus(3'd5, 32'd100, 32'd7, res, lat);
    checkOutput("bp result", res, 32'd14);
    checkOutput("bp latency", 32'(lat), 32'd32);
    @(negedge clk);
    v_drv  = 1'b1;
    op_drv = 3'd0;
    a_drv  = 32'd3;
    b_drv  = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp out stable", cur_out, 32'd14);
      checkOutput("bp in_ready low", 32'(cur_in_ready), 32'd0);
      checkOutput("bp out_valid held", 32'(cur_out_valid), 32'd1);
    end
    @(negedge clk);
    rdy_drv = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release in_ready", 32'(cur_in_ready), 32'd1);
    checkOutput("bp release out_valid", 32'(cur_out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp next accepted", 32'(cur_in_ready), 32'd0);
    v_drv = 1'b0;
    waitResult(res, lat);
    checkOutput("bp next result", res, 32'd15);
    checkOutput("bp next latency", 32'(lat), 32'd32);
    @(posedge clk); #1;

    // Flush at BUSY iteration 5 with a request presented in the flush edge
    @(negedge clk);
    v_drv  = 1'b1;
    op_drv = 3'd0;
    a_drv  = $urandom;
    b_drv  = $urandom;
    @(posedge clk); #1;
    v_drv = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush  = 1'b1;
    v_drv  = 1'b1;
    op_drv = 3'd2;
    a_drv  = 32'hFFFF_FFFF;
    b_drv  = 32'h0000_0002;
    @(posedge clk); #1;
    checkOutput("flush busy in_ready", 32'(cur_in_ready), 32'd1);
    checkOutput("flush busy out_valid", 32'(cur_out_valid), 32'd0);
    flush = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-flush accepted", 32'(cur_in_ready), 32'd0);
    v_drv = 1'b0;
    waitResult(res, lat);
    checkOutput("post-flush MULHSU result", res, 32'hFFFF_FFFF);
    checkOutput("post-flush MULHSU latency", 32'(lat), 32'd32);
    @(posedge clk); #1;

    // Flush while DONE
    rdy_drv = 1'b0;
    applyStimulus(3'd4, 32'd5, 32'd0, res, lat);
    checkOutput("flush done pre result", res, 32'hFFFF_FFFF);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush done out_valid", 32'(cur_out_valid), 32'd0);
    checkOutput("flush done in_ready", 32'(cur_in_ready), 32'd1);
    rdy_drv = 1'b1;

    // Reset mid-BUSY: no result may ever appear
    @(negedge clk);
    v_drv  = 1'b1;
    op_drv = 3'd1;
    a_drv  = 32'h1234_5678;
    b_drv  = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    v_drv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("reset busy out_valid", 32'(cur_out_valid), 32'd0);
    checkOutput("reset busy out", cur_out, 32'd0);
    checkOutput("reset busy in_ready", 32'(cur_in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (cur_out_valid) seen++;
    end
    checkOutput("reset busy no late out_valid", 32'(seen), 32'd0);

    // Reset while DONE clears the held result
    rdy_drv = 1'b0;
    applyStimulus(3'd5, 32'd7, 32'd2, res, lat);
    checkOutput("reset done pre result", res, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("reset done out_valid", 32'(cur_out_valid), 32'd0);
    checkOutput("reset done out", cur_out, 32'd0);
    checkOutput("reset done in_ready", 32'(cur_in_ready), 32'd1);
    rdy_drv = 1'b1;

    // Random ops, XLEN = 32
    for (int i = 0; i < 40; i++) begin
      genOperands(32, op, a, b);
      applyStimulus(op, a, b, res, lat);
      checkOutput($sformatf("rand32 #%0d op%0d a=%08h b=%08h result", i, op, a, b), res, model(op, a, b, 32));
      checkOutput($sformatf("rand32 #%0d latency", i), 32'(lat), 32'(expLat(op, a, b, 32)));
    end

    // Random ops, XLEN = 8
    @(negedge clk);
    use8 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      genOperands(8, op, a, b);
      applyStimulus(op, a, b, res, lat);
      checkOutput($sformatf("rand8 #%0d op%0d a=%02h b=%02h result", i, op, a[7:0], b[7:0]), res, model(op, a, b, 8));
      checkOutput($sformatf("rand8 #%0d latency", i), 32'(lat), 32'(expLat(op, a, b, 8)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
